// File: rtl/network_output_schedule_pkg.sv
// Shared types and widths for the per-port output scheduler.
// Imported by the top level and by the per-priority buffer-ID FIFO.
package network_output_schedule_pkg;

  localparam int BUFID_W = 9;
  localparam int PRI_W   = 3;
  localparam int NUM_Q   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_WAIT  = 2'd2
  } osc_state_e;

endpackage

// File: rtl/network_output_schedule_bufid_fifo.sv
// Single-priority circular buffer of packet buffer IDs.
// The head entry is visible without popping; push/pop are ignored when full/empty.
module network_output_schedule_bufid_fifo
  import network_output_schedule_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [BUFID_W-1:0] din,
  output logic [BUFID_W-1:0] head,
  output logic [AW:0]        count,
  output logic               empty,
  output logic               full
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [BUFID_W-1:0] mem_q [DEPTH];
  logic [BUFID_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic               push_ok;
  logic               pop_ok;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Push and pop together leave the occupancy unchanged.
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/network_output_schedule.sv
// Strict-priority output scheduler: eight gated per-priority queues feeding network_tx,
// with full-queue drops returned to the buffer manager on the release port.
module network_output_schedule
  import network_output_schedule_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [BUFID_W-1:0] iv_pkt_bufid,
  input  logic [PRI_W-1:0]   iv_pkt_pri,
  input  logic               i_pkt_wr,
  input  logic [NUM_Q-1:0]   iv_gate_ctrl,
  output logic [BUFID_W-1:0] ov_pkt_bufid,
  output logic               o_pkt_bufid_wr,
  input  logic               i_pkt_bufid_ack,
  output logic [BUFID_W-1:0] ov_release_bufid,
  output logic               o_release_wr,
  output logic [NUM_Q-1:0]   ov_queue_empty,
  output logic [15:0]        ov_drop_cnt,
  output logic [1:0]         ov_osc_state
);

  logic [BUFID_W-1:0] head [NUM_Q];
  logic [AW:0]        count [NUM_Q];
  logic [NUM_Q-1:0]   empty;
  logic [NUM_Q-1:0]   full;
  logic [NUM_Q-1:0]   push_vec;
  logic [NUM_Q-1:0]   pop_vec;
  logic [NUM_Q-1:0]   eligible;
  logic [PRI_W-1:0]   sel_next;
  logic               drop;
  logic               ack_ok;

  osc_state_e         state_q, state_d;
  logic [PRI_W-1:0]   sel_q, sel_d;
  logic [BUFID_W-1:0] bufid_q, bufid_d;
  logic [BUFID_W-1:0] release_bufid_q, release_bufid_d;
  logic               release_wr_q, release_wr_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;

  for (genvar q = 0; q < NUM_Q; q++) begin : g_queue
    network_output_schedule_bufid_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_fifo (
      .clk   (i_clk),
      .rst   (i_rst),
      .push  (push_vec[q]),
      .pop   (pop_vec[q]),
      .din   (iv_pkt_bufid),
      .head  (head[q]),
      .count (count[q]),
      .empty (empty[q]),
      .full  (full[q])
    );
    assign eligible[q] = (count[q] != '0) && iv_gate_ctrl[q];
  end

  assign ack_ok = i_pkt_bufid_ack && (state_q != ST_IDLE);

  // Fullness is judged on the pre-pop count, so a same-cycle pop cannot rescue an enqueue.
  always_comb begin
    push_vec = '0;
    pop_vec  = '0;
    drop     = 1'b0;
    if (i_pkt_wr) begin
      if (full[iv_pkt_pri]) begin
        drop = 1'b1;
      end else begin
        push_vec[iv_pkt_pri] = 1'b1;
      end
    end
    if (ack_ok) begin
      pop_vec[sel_q] = 1'b1;
    end
  end

  always_comb begin
    sel_next = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      if (eligible[i]) begin
        sel_next = PRI_W'(i);
      end
    end
  end

  // Once offered, the ID and its queue index stay frozen until network_tx acknowledges.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    bufid_d = bufid_q;
    case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          bufid_d = head[sel_next];
          sel_d   = sel_next;
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: state_d = ack_ok ? ST_IDLE : ST_WAIT;
      ST_WAIT: begin
        if (ack_ok) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    release_wr_d    = drop;
    release_bufid_d = drop ? iv_pkt_bufid : release_bufid_q;
    drop_cnt_d      = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q         <= ST_IDLE;
      sel_q           <= '0;
      bufid_q         <= '0;
      release_bufid_q <= '0;
      release_wr_q    <= 1'b0;
      drop_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      sel_q           <= sel_d;
      bufid_q         <= bufid_d;
      release_bufid_q <= release_bufid_d;
      release_wr_q    <= release_wr_d;
      drop_cnt_q      <= drop_cnt_d;
    end
  end

  assign ov_pkt_bufid     = bufid_q;
  assign o_pkt_bufid_wr   = (state_q != ST_IDLE);
  assign ov_release_bufid = release_bufid_q;
  assign o_release_wr     = release_wr_q;
  assign ov_queue_empty   = empty;
  assign ov_drop_cnt      = drop_cnt_q;
  assign ov_osc_state     = state_q;

endmodule

// File: tb/tb_network_output_schedule.sv
// Directed bench for network_output_schedule: expected offers are queued by the stimulus
// and compared in order as the scheduler presents each buffer ID.
module tb_network_output_schedule;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [8:0] iv_pkt_bufid;
  logic [2:0] iv_pkt_pri;
  logic       i_pkt_wr;
  logic [7:0] iv_gate_ctrl;
  logic [8:0] ov_pkt_bufid;
  logic       o_pkt_bufid_wr;
  logic       i_pkt_bufid_ack;
  logic [8:0] ov_release_bufid;
  logic       o_release_wr;
  logic [7:0] ov_queue_empty;
  logic [15:0] ov_drop_cnt;
  logic [1:0] ov_osc_state;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q [$];

  network_output_schedule #(
    .DEPTH (16),
    .AW    (4)
  ) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .iv_pkt_bufid     (iv_pkt_bufid),
    .iv_pkt_pri       (iv_pkt_pri),
    .i_pkt_wr         (i_pkt_wr),
    .iv_gate_ctrl     (iv_gate_ctrl),
    .ov_pkt_bufid     (ov_pkt_bufid),
    .o_pkt_bufid_wr   (o_pkt_bufid_wr),
    .i_pkt_bufid_ack  (i_pkt_bufid_ack),
    .ov_release_bufid (ov_release_bufid),
    .o_release_wr     (o_release_wr),
    .ov_queue_empty   (ov_queue_empty),
    .ov_drop_cnt      (ov_drop_cnt),
    .ov_osc_state     (ov_osc_state)
  );

  always #4 i_clk = ~i_clk;

  task automatic cyc();
    @(negedge i_clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One-cycle enqueue strobe; returns at the following negedge with the strobe dropped.
  task automatic applyStimulus(input logic [8:0] id, input logic [2:0] pri);
    iv_pkt_bufid = id;
    iv_pkt_pri   = pri;
    i_pkt_wr     = 1'b1;
    cyc();
    i_pkt_wr     = 1'b0;
  endtask

  task automatic expectOffer(input logic [8:0] id);
    exp_q.push_back(id);
  endtask

  task automatic waitOffer(input string tag, input int max_cycles);
    int n;
    logic [8:0] exp_id;
    n = 0;
    while (o_pkt_bufid_wr !== 1'b1 && n < max_cycles) begin
      cyc();
      n++;
    end
    checks++;
    assert (o_pkt_bufid_wr === 1'b1) else begin
      errors++;
      $error("[TB] FAIL %s_timeout: o_pkt_bufid_wr observed %0b expected 1", tag, o_pkt_bufid_wr);
    end
    if (o_pkt_bufid_wr === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("[TB] FAIL %s_unexpected: observed offer 0x%0h expected none", tag, ov_pkt_bufid);
      end
      if (exp_q.size() != 0) begin
        exp_id = exp_q.pop_front();
        checkOutput(tag, 32'(ov_pkt_bufid), 32'(exp_id));
      end
    end
  endtask

  // Acknowledge the current offer, optionally with a same-cycle enqueue.
  task automatic ack(input logic do_wr, input logic [8:0] id, input logic [2:0] pri);
    i_pkt_bufid_ack = 1'b1;
    i_pkt_wr        = do_wr;
    iv_pkt_bufid    = id;
    iv_pkt_pri      = pri;
    cyc();
    i_pkt_bufid_ack = 1'b0;
    i_pkt_wr        = 1'b0;
    checkOutput("ack_wr_low", 32'(o_pkt_bufid_wr), 32'd0);
    checkOutput("ack_idle", 32'(ov_osc_state), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_rst           = 1'b1;
    iv_pkt_bufid    = '0;
    iv_pkt_pri      = '0;
    i_pkt_wr        = 1'b0;
    iv_gate_ctrl    = 8'hFF;
    i_pkt_bufid_ack = 1'b0;
    cyc();
    cyc();
    i_rst = 1'b0;
    cyc();

    $display("[TB] reset state");
    checkOutput("rst_bufid", 32'(ov_pkt_bufid), 32'd0);
    checkOutput("rst_wr", 32'(o_pkt_bufid_wr), 32'd0);
    checkOutput("rst_rel_id", 32'(ov_release_bufid), 32'd0);
    checkOutput("rst_rel_wr", 32'(o_release_wr), 32'd0);
    checkOutput("rst_empty", 32'(ov_queue_empty), 32'hFF);
    checkOutput("rst_drop", 32'(ov_drop_cnt), 32'd0);
    checkOutput("rst_state", 32'(ov_osc_state), 32'd0);

    $display("[TB] single ID");
    applyStimulus(9'h015, 3'd3);
    checkOutput("t1_empty_t1", 32'(ov_queue_empty), 32'hF7);
    checkOutput("t1_wr_t1", 32'(o_pkt_bufid_wr), 32'd0);
    cyc();
    expectOffer(9'h015);
    waitOffer("t1_offer_t2", 0);
    checkOutput("t1_state_offer", 32'(ov_osc_state), 32'd1);
    cyc();
    checkOutput("t1_state_wait", 32'(ov_osc_state), 32'd2);
    cyc();
    cyc();
    checkOutput("t1_hold_id", 32'(ov_pkt_bufid), 32'h015);
    checkOutput("t1_hold_wr", 32'(o_pkt_bufid_wr), 32'd1);
    ack(1'b0, 9'h000, 3'd0);
    checkOutput("t1_empty_after", 32'(ov_queue_empty), 32'hFF);

    $display("[TB] priority order");
    iv_gate_ctrl = 8'h00;
    applyStimulus(9'h001, 3'd0);
    applyStimulus(9'h002, 3'd5);
    applyStimulus(9'h003, 3'd7);
    checkOutput("t2_empty", 32'(ov_queue_empty), 32'h5E);
    checkOutput("t2_gated_idle", 32'(ov_osc_state), 32'd0);
    iv_gate_ctrl = 8'hFF;
    expectOffer(9'h003);
    expectOffer(9'h002);
    expectOffer(9'h001);
    for (int k = 0; k < 3; k++) begin
      waitOffer("t2_prio", 8);
      ack(1'b0, 9'h000, 3'd0);
    end

    $display("[TB] gating");
    iv_gate_ctrl = 8'h04;
    applyStimulus(9'h070, 3'd7);
    i_pkt_bufid_ack = 1'b1;
    cyc();
    i_pkt_bufid_ack = 1'b0;
    checkOutput("t3_ack_ignored_state", 32'(ov_osc_state), 32'd0);
    checkOutput("t3_ack_ignored_q7", 32'(ov_queue_empty[7]), 32'd0);
    expectOffer(9'h020);
    expectOffer(9'h070);
    applyStimulus(9'h020, 3'd2);
    waitOffer("t3_gated", 8);
    iv_gate_ctrl = 8'hFF;
    cyc();
    cyc();
    checkOutput("t3_no_retract", 32'(ov_pkt_bufid), 32'h020);
    ack(1'b0, 9'h000, 3'd0);
    waitOffer("t3_next", 8);
    ack(1'b0, 9'h000, 3'd0);

    $display("[TB] full queue and drop");
    iv_gate_ctrl = 8'h02;
    for (int k = 0; k < 17; k++) begin
      applyStimulus(9'(9'h100 + k), 3'd1);
    end
    checkOutput("t4_rel_wr", 32'(o_release_wr), 32'd1);
    checkOutput("t4_rel_id", 32'(ov_release_bufid), 32'h110);
    checkOutput("t4_drop1", 32'(ov_drop_cnt), 32'd1);
    cyc();
    checkOutput("t4_rel_pulse", 32'(o_release_wr), 32'd0);
    checkOutput("t4_drop1_hold", 32'(ov_drop_cnt), 32'd1);
    expectOffer(9'h100);
    waitOffer("t4_head", 0);
    checkOutput("t4_state_wait", 32'(ov_osc_state), 32'd2);
    i_pkt_wr        = 1'b1;
    iv_pkt_bufid    = 9'h1AA;
    iv_pkt_pri      = 3'd1;
    i_pkt_bufid_ack = 1'b1;
    cyc();
    i_pkt_wr        = 1'b0;
    i_pkt_bufid_ack = 1'b0;
    checkOutput("t4_popdrop_rel_wr", 32'(o_release_wr), 32'd1);
    checkOutput("t4_popdrop_rel_id", 32'(ov_release_bufid), 32'h1AA);
    checkOutput("t4_drop2", 32'(ov_drop_cnt), 32'd2);
    checkOutput("t4_popdrop_wr", 32'(o_pkt_bufid_wr), 32'd0);
    applyStimulus(9'h1BB, 3'd1);
    checkOutput("t4_refill_ok", 32'(o_release_wr), 32'd0);
    checkOutput("t4_drop2_hold", 32'(ov_drop_cnt), 32'd2);
    applyStimulus(9'h1CC, 3'd1);
    checkOutput("t4_refull_rel_wr", 32'(o_release_wr), 32'd1);
    checkOutput("t4_refull_rel_id", 32'(ov_release_bufid), 32'h1CC);
    checkOutput("t4_drop3", 32'(ov_drop_cnt), 32'd3);
    for (int k = 1; k < 16; k++) begin
      expectOffer(9'(9'h100 + k));
    end
    expectOffer(9'h1BB);
    for (int k = 0; k < 16; k++) begin
      waitOffer("t4_drain", 8);
      ack(1'b0, 9'h000, 3'd0);
    end
    checkOutput("t4_empty", 32'(ov_queue_empty), 32'hFF);

    $display("[TB] pointer wrap");
    iv_gate_ctrl = 8'hFF;
    for (int k = 0; k < 40; k++) begin
      expectOffer(9'(9'h040 + k));
    end
    applyStimulus(9'h040, 3'd4);
    applyStimulus(9'h041, 3'd4);
    applyStimulus(9'h042, 3'd4);
    for (int k = 0; k < 40; k++) begin
      waitOffer("t5_wrap", 8);
      if (k + 3 < 40) begin
        ack(1'b1, 9'(9'h040 + k + 3), 3'd4);
      end else begin
        ack(1'b0, 9'h000, 3'd0);
      end
    end
    checkOutput("t5_empty4", 32'(ov_queue_empty[4]), 32'd1);
    checkOutput("t5_no_drop", 32'(ov_drop_cnt), 32'd3);

    $display("[TB] reset mid-offer");
    expectOffer(9'h055);
    applyStimulus(9'h055, 3'd6);
    waitOffer("t6_offer", 8);
    cyc();
    checkOutput("t6_state_wait", 32'(ov_osc_state), 32'd2);
    #2;
    i_rst = 1'b1;
    #1;
    checkOutput("t6_async_wr", 32'(o_pkt_bufid_wr), 32'd0);
    checkOutput("t6_async_empty", 32'(ov_queue_empty), 32'hFF);
    checkOutput("t6_async_state", 32'(ov_osc_state), 32'd0);
    checkOutput("t6_async_drop", 32'(ov_drop_cnt), 32'd0);
    cyc();
    i_rst = 1'b0;
    cyc();
    cyc();
    cyc();
    checkOutput("t6_id_lost", 32'(o_pkt_bufid_wr), 32'd0);
    checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
